// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer: state encoding and default widths.
package timer_pkg;

  localparam int TIMER_WIDTH_DEFAULT      = 16;
  localparam int TIMER_PRESCALE_W_DEFAULT = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } timer_state_e;

endpackage : timer_pkg

// File: rtl/tick_prescaler.sv
// Tick divider: pulses tick every (setting + 1) enabled cycles; the setting is captured on clear.
module tick_prescaler #(
  parameter int PRESCALE_W = timer_pkg::TIMER_PRESCALE_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_async,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] setting_q;
  logic [PRESCALE_W-1:0] div_q;

  assign tick = enable && (div_q == setting_q);

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples the pre-edge values of its neighbours regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst_async) begin
      setting_q <= '0;
      div_q     <= '0;
    end else if (clear) begin
      setting_q <= prescale;
      div_q     <= '0;
    end else if (enable) begin
      div_q <= tick ? '0 : div_q + 1'b1;
    end
  end

endmodule : tick_prescaler

// File: rtl/countdown_timer_16bit.sv
// Loadable down-counting timer with stop/start, one-shot or auto-reload, and a done pulse.
// Define COUNTDOWN_PRESCALE_EN to add the prescale port and tick_prescaler divider.
module countdown_timer_16bit
  import timer_pkg::*;
#(
  parameter int WIDTH = TIMER_WIDTH_DEFAULT
`ifdef COUNTDOWN_PRESCALE_EN
  ,
  parameter int PRESCALE_W = TIMER_PRESCALE_W_DEFAULT
`endif
) (
  input  logic                  clk,
  input  logic                  rst_async,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  auto_reload,
`ifdef COUNTDOWN_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  done
);

  timer_state_e     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] eff_count;
  logic             tick;

`ifdef COUNTDOWN_PRESCALE_EN
  logic div_clear;

  // Divider restarts on entry to RUN and whenever a running interval is reloaded.
  assign div_clear = ((state_q == IDLE) && (state_d == RUN)) ||
                     ((state_q == RUN) && !stop && load && (load_value != '0));

  tick_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_tick_prescaler (
    .clk       (clk),
    .rst_async (rst_async),
    .clear     (div_clear),
    .enable    (state_q == RUN),
    .prescale  (prescale),
    .tick      (tick)
  );
`else
  assign tick = 1'b1;
`endif

  assign eff_count = load ? load_value : count_q;

  // NOTE: every variable driven here gets a default first; a path that leaves one
  // unassigned would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!stop) begin
          if (load) begin
            count_d  = load_value;
            reload_d = load_value;
          end
          if (start) begin
            if (eff_count != '0) state_d = RUN;
            else                 done_d  = 1'b1;
          end
        end
      end

      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (load) begin
          count_d  = load_value;
          reload_d = load_value;
          if (load_value == '0) state_d = IDLE;
        end else if (tick) begin
          if (count_q == WIDTH'(1)) begin
            done_d = 1'b1;
            if (auto_reload) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = IDLE;
            end
          end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_async) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = (state_q == RUN);
  assign done  = done_q;

endmodule : countdown_timer_16bit

// File: tb/tb_countdown_timer_16bit.sv
// Directed self-checking bench for countdown_timer_16bit; expected values are hand-computed.
module tb_countdown_timer_16bit;

  logic        clk = 1'b0;
  logic        rst_async;
  logic        load;
  logic [15:0] load_value;
  logic        start;
  logic        stop;
  logic        auto_reload;
  logic [15:0] count;
  logic        busy;
  logic        done;
`ifdef COUNTDOWN_PRESCALE_EN
  logic [7:0]  prescale;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  countdown_timer_16bit dut (
    .clk         (clk),
    .rst_async   (rst_async),
    .load        (load),
    .load_value  (load_value),
    .start       (start),
    .stop        (stop),
    .auto_reload (auto_reload),
`ifdef COUNTDOWN_PRESCALE_EN
    .prescale    (prescale),
`endif
    .count       (count),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply current inputs for one edge, then drop the single-cycle controls.
  task automatic step();
    @(posedge clk);
    #1;
    load  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int unsigned c, input bit b, input bit d);
    check({tag, ".count"}, count, c);
    check({tag, ".busy"},  busy,  b);
    check({tag, ".done"},  done,  d);
  endtask

  task automatic load_start(input int unsigned v);
    load = 1'b1; load_value = 16'(v); start = 1'b1;
    step();
  endtask

  initial begin
    rst_async = 1'b1; load = 1'b0; load_value = '0; start = 1'b0;
    stop = 1'b0; auto_reload = 1'b0;
`ifdef COUNTDOWN_PRESCALE_EN
    prescale = '0;
`endif
    step(); step();
    expect_out("reset", 0, 0, 0);
    rst_async = 1'b0;

    // One-shot: load 3 + start together.
    load_start(3);          expect_out("os_n",   3, 1, 0);
    step();                 expect_out("os_n1",  2, 1, 0);
    step();                 expect_out("os_n2",  1, 1, 0);
    step();                 expect_out("os_n3",  0, 0, 1);
    step();                 expect_out("os_after", 0, 0, 0);

    // Load in IDLE without start only updates count.
    load = 1'b1; load_value = 16'd9;
    step();                 expect_out("idle_load", 9, 0, 0);

    // Auto-reload with interval 2.
    auto_reload = 1'b1;
    load_start(2);          expect_out("ar_0", 2, 1, 0);
    step();                 expect_out("ar_1", 1, 1, 0);
    step();                 expect_out("ar_2", 2, 1, 1);
    step();                 expect_out("ar_3", 1, 1, 0);
    step();                 expect_out("ar_4", 2, 1, 1);
    stop = 1'b1;
    step();                 expect_out("ar_stop", 2, 0, 0);

    // Reload value 1 with auto-reload: done every tick.
    load_start(1);          expect_out("ar1_0", 1, 1, 0);
    step();                 expect_out("ar1_1", 1, 1, 1);
    step();                 expect_out("ar1_2", 1, 1, 1);
    stop = 1'b1;
    step();                 expect_out("ar1_stop", 1, 0, 0);
    auto_reload = 1'b0;

    // Stop overrides a coincident start; count is frozen, resume decrements.
    load_start(6);          expect_out("st_0", 6, 1, 0);
    step();                 expect_out("st_1", 5, 1, 0);
    step();                 expect_out("st_2", 4, 1, 0);
    stop = 1'b1; start = 1'b1;
    step();                 expect_out("st_stop", 4, 0, 0);
    step();                 expect_out("st_hold", 4, 0, 0);
    start = 1'b1;
    step();                 expect_out("st_resume", 4, 1, 0);
    step();                 expect_out("st_dec", 3, 1, 0);

    // Load nonzero while running restarts the interval.
    load = 1'b1; load_value = 16'd9;
    step();                 expect_out("rl_9", 9, 1, 0);
    step();                 expect_out("rl_8", 8, 1, 0);

    // Load zero while running returns to IDLE without done.
    load = 1'b1; load_value = 16'd0;
    step();                 expect_out("rl_zero", 0, 0, 0);
    step();                 expect_out("rl_zero_after", 0, 0, 0);

    // Start with count 0: single done pulse, never busy.
    start = 1'b1;
    step();                 expect_out("z_start", 0, 0, 1);
    step();                 expect_out("z_after", 0, 0, 0);

    // Reset mid-run: count cleared, no done.
    load_start(5);          expect_out("rs_0", 5, 1, 0);
    step();                 expect_out("rs_1", 4, 1, 0);
    step();                 expect_out("rs_2", 3, 1, 0);
    rst_async = 1'b1; start = 1'b1; load = 1'b1; load_value = 16'd7;
    step();                 expect_out("rs_rst", 0, 0, 0);
    rst_async = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();               expect_out("rs_quiet", 0, 0, 0);
    end

`ifdef COUNTDOWN_PRESCALE_EN
    // Prescale 2: one decrement per three cycles, done six edges after start.
    prescale = 8'd2;
    load_start(2);          expect_out("ps_0", 2, 1, 0);
    step();                 expect_out("ps_1", 2, 1, 0);
    step();                 expect_out("ps_2", 2, 1, 0);
    step();                 expect_out("ps_3", 1, 1, 0);
    step();                 expect_out("ps_4", 1, 1, 0);
    step();                 expect_out("ps_5", 1, 1, 0);
    step();                 expect_out("ps_6", 0, 0, 1);
    prescale = '0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_countdown_timer_16bit
